// File: rtl/pulse_period_checker.sv
// -----------------------------------------------------------------------------
// pulse_period_checker
//
// Receive-side monitor for a periodic single-cycle pulse stream. While enabled
// it detects rising edges on pulse_in and measures the gap between consecutive
// edges. A gap of exactly PERIOD is good. A shorter gap is an early error. A
// missing edge at gap == PERIOD is a late error. The block asserts lock after
// LOCK_COUNT consecutive good intervals and keeps saturating good and error
// counters.
//
// Parameters
//   PERIOD      expected edge-to-edge gap in clk cycles (>= 2)
//   LOCK_COUNT  consecutive good intervals needed for lock (>= 1)
//   CNT_W       width of the interval and event counters (must hold PERIOD+1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active high; clears all state
//   en          checking enable; low forces IDLE and drops lock
//   pulse_in    monitored pulse stream
//   locked      high after LOCK_COUNT consecutive good intervals
//   err_early   one-cycle strobe: edge arrived with gap < PERIOD
//   err_late    one-cycle strobe: no edge by gap == PERIOD
//   interval    gap measured at the last edge seen while tracking
//   good_count  saturating count of good intervals
//   err_count   saturating count of early plus late errors
// -----------------------------------------------------------------------------
module pulse_period_checker #(
  parameter int PERIOD     = 10,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  output logic             locked,
  output logic             err_early,
  output logic             err_late,
  output logic [CNT_W-1:0] interval,
  output logic [CNT_W-1:0] good_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_TRACK   = 2'd2;

  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_COUNT);

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]       state_q,      state_d;
  logic             pulse_d_q;
  logic [CNT_W-1:0] gap_q,        gap_d;
  logic [CNT_W-1:0] run_q,        run_d;
  logic             locked_q,     locked_d;
  logic             err_early_q,  err_early_d;
  logic             err_late_q,   err_late_d;
  logic [CNT_W-1:0] interval_q,   interval_d;
  logic [CNT_W-1:0] good_count_q, good_count_d;
  logic [CNT_W-1:0] err_count_q,  err_count_d;

  logic             edge_det;
  logic [CNT_W-1:0] run_inc;

  // A level held high produces a single edge because pulse_d follows it.
  assign edge_det = pulse_in & ~pulse_d_q;
  assign run_inc  = sat_inc(run_q);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    gap_d        = edge_det ? CNT_W'(1) : sat_inc(gap_q);
    run_d        = run_q;
    locked_d     = locked_q;
    err_early_d  = 1'b0;
    err_late_d   = 1'b0;
    interval_d   = interval_q;
    good_count_d = good_count_q;
    err_count_d  = err_count_q;

    if (!en) begin
      // Disable wins over any simultaneous edge: no count, no strobe.
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      run_d    = '0;
      gap_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An edge on the enabling cycle is deliberately ignored.
          state_d = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          // First edge only establishes the time reference; gap restarts at 1.
          if (edge_det) state_d = ST_TRACK;
        end

        ST_TRACK: begin
          if (edge_det) begin
            interval_d = gap_q;
            if (gap_q == PERIOD_C) begin
              // An edge exactly at PERIOD is good, never late.
              good_count_d = sat_inc(good_count_q);
              run_d        = run_inc;
              if (run_inc >= LOCK_C) locked_d = 1'b1;
            end else if (gap_q < PERIOD_C) begin
              err_early_d = 1'b1;
              err_count_d = sat_inc(err_count_q);
              run_d       = '0;
              locked_d    = 1'b0;
            end
          end else if (gap_q == PERIOD_C) begin
            // Edge overdue: report once and fall back to re-acquisition.
            err_late_d  = 1'b1;
            err_count_d = sat_inc(err_count_q);
            run_d       = '0;
            locked_d    = 1'b0;
            state_d     = ST_ACQUIRE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pulse_d_q    <= 1'b0;
      gap_q        <= '0;
      run_q        <= '0;
      locked_q     <= 1'b0;
      err_early_q  <= 1'b0;
      err_late_q   <= 1'b0;
      interval_q   <= '0;
      good_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this clock edge, independent of statement order.
      state_q      <= state_d;
      pulse_d_q    <= pulse_in;
      gap_q        <= gap_d;
      run_q        <= run_d;
      locked_q     <= locked_d;
      err_early_q  <= err_early_d;
      err_late_q   <= err_late_d;
      interval_q   <= interval_d;
      good_count_q <= good_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign locked     = locked_q;
  assign err_early  = err_early_q;
  assign err_late   = err_late_q;
  assign interval   = interval_q;
  assign good_count = good_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_checker
//
// Drives directed scenarios followed by randomized pulse trains into
// pulse_period_checker. A timestamp-based reference model (last edge cycle,
// elapsed cycles) predicts every output; a compare process checks the DUT
// against it on each falling clock edge, and directed literal checks pin the
// model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_pulse_period_checker;

  localparam int PERIOD     = 10;
  localparam int LOCK_COUNT = 3;
  localparam int CNT_W      = 16;
  localparam int MAXC       = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic             pulse_in;
  logic             locked;
  logic             err_early;
  logic             err_late;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] good_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_period_checker #(
    .PERIOD    (PERIOD),
    .LOCK_COUNT(LOCK_COUNT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pulse_in  (pulse_in),
    .locked    (locked),
    .err_early (err_early),
    .err_late  (err_late),
    .interval  (interval),
    .good_count(good_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks when the last edge happened and how many cycles
  // have elapsed since, rather than a running gap register.
  // ---------------------------------------------------------------------------
  typedef enum int {M_IDLE, M_ACQ, M_TRACK} mode_t;

  mode_t m_mode;
  bit    m_prev;
  int    m_cyc, m_last, m_run;
  bit    m_locked, m_early, m_late;
  int    m_interval, m_good, m_err;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_prev = 1'b0; m_cyc = 0; m_last = 0; m_run = 0;
      m_locked = 1'b0; m_early = 1'b0; m_late = 1'b0;
      m_interval = 0; m_good = 0; m_err = 0;
    end else begin
      bit e;
      int elapsed;
      e       = pulse_in && !m_prev;
      m_prev  = pulse_in;
      m_cyc   = m_cyc + 1;
      m_early = 1'b0;
      m_late  = 1'b0;
      elapsed = m_cyc - m_last;
      if (!en) begin
        m_mode = M_IDLE; m_locked = 1'b0; m_run = 0;
      end else if (m_mode == M_IDLE) begin
        m_mode = M_ACQ;
      end else if (m_mode == M_ACQ) begin
        if (e) begin m_mode = M_TRACK; m_last = m_cyc; end
      end else begin
        if (e) begin
          m_interval = elapsed;
          if (elapsed == PERIOD) begin
            m_good = sat(m_good);
            m_run  = m_run + 1;
            if (m_run >= LOCK_COUNT) m_locked = 1'b1;
          end else begin
            m_early = 1'b1; m_err = sat(m_err); m_run = 0; m_locked = 1'b0;
          end
          m_last = m_cyc;
        end else if (elapsed == PERIOD) begin
          m_late = 1'b1; m_err = sat(m_err); m_run = 0; m_locked = 1'b0;
          m_mode = M_ACQ;
        end
      end
    end
  end

  // Compare process: outputs settle after the rising edge, sample on falling.
  always @(negedge clk) begin
    if (!rst) begin
      check("locked",     32'(locked),     32'(m_locked));
      check("err_early",  32'(err_early),  32'(m_early));
      check("err_late",   32'(err_late),   32'(m_late));
      check("interval",   32'(interval),   32'(m_interval));
      check("good_count", 32'(good_count), 32'(m_good));
      check("err_count",  32'(err_count),  32'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change only on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Edge sampled g cycles after the previous one; returns on the falling edge
  // right after the sampling clock, where the response is visible.
  task automatic pulse_after(input int g);
    repeat (g - 1) tick();
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_locked", 32'(locked),     32'd0);
    check("rst_good",   32'(good_count), 32'd0);
    check("rst_err",    32'(err_count),  32'd0);
    check("rst_intv",   32'(interval),   32'd0);
    check("rst_strobe", 32'(err_early | err_late), 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int early_seen, late_seen;
    rst      = 1'b0;
    en       = 1'b0;
    pulse_in = 1'b0;

    // Reset between clocks.
    async_reset();

    // Nominal: acquire, then three good intervals lock.
    en = 1'b1;
    tick();                       // IDLE -> ACQUIRE
    pulse_after(3);               // acquire
    check("acq_good", 32'(good_count), 32'd0);
    pulse_after(PERIOD);
    check("nom_good1", 32'(good_count), 32'd1);
    pulse_after(PERIOD);
    check("nom_good2",   32'(good_count), 32'd2);
    check("nom_unlock2", 32'(locked),     32'd0);
    pulse_after(PERIOD);
    check("nom_good3",  32'(good_count), 32'd3);
    check("nom_locked", 32'(locked),     32'd1);
    check("nom_intv",   32'(interval),   32'd10);
    check("nom_err",    32'(err_count),  32'd0);

    // Early pulse.
    pulse_after(7);
    check("early_strobe", 32'(err_early), 32'd1);
    check("early_unlock", 32'(locked),    32'd0);
    check("early_err",    32'(err_count), 32'd1);
    check("early_intv",   32'(interval),  32'd7);
    tick();
    check("early_oneshot", 32'(err_early), 32'd0);
    pulse_after(PERIOD - 1);
    check("after_early_good", 32'(good_count), 32'd4);
    pulse_after(PERIOD);
    pulse_after(PERIOD);
    check("relock", 32'(locked), 32'd1);

    // Missing pulse: late strobe exactly PERIOD after the last edge.
    repeat (PERIOD - 1) tick();
    check("late_not_yet", 32'(err_late), 32'd0);
    tick();
    check("late_strobe", 32'(err_late),  32'd1);
    check("late_unlock", 32'(locked),    32'd0);
    check("late_err",    32'(err_count), 32'd2);
    tick();
    check("late_oneshot", 32'(err_late), 32'd0);
    pulse_after(5);               // re-acquire, no count change
    check("reacq_good", 32'(good_count), 32'd6);
    check("reacq_err",  32'(err_count),  32'd2);
    pulse_after(PERIOD);
    check("reacq_track", 32'(good_count), 32'd7);

    // Stuck high: one good edge, then exactly one late error.
    repeat (PERIOD - 1) tick();
    pulse_in   = 1'b1;
    early_seen = 0;
    late_seen  = 0;
    repeat (25) begin
      tick();
      if (err_early) early_seen++;
      if (err_late)  late_seen++;
    end
    pulse_in = 1'b0;
    tick();
    check("stuck_late_cnt",  32'(late_seen),  32'd1);
    check("stuck_early_cnt", 32'(early_seen), 32'd0);
    check("stuck_err",       32'(err_count),  32'd3);

    // Enable drop while locked.
    pulse_after(3);
    repeat (3) pulse_after(PERIOD);
    check("pre_dis_locked", 32'(locked), 32'd1);
    en = 1'b0;
    tick();
    check("dis_unlock", 32'(locked), 32'd0);
    pulse_after(PERIOD);
    pulse_after(5);
    check("dis_good_held", 32'(good_count), 32'd11);
    check("dis_err_held",  32'(err_count),  32'd3);
    check("dis_intv_held", 32'(interval),   32'd10);
    en = 1'b1;
    tick();
    pulse_after(4);
    pulse_after(PERIOD);
    pulse_after(PERIOD);
    check("reen_not_locked", 32'(locked), 32'd0);
    pulse_after(PERIOD);
    check("reen_locked", 32'(locked), 32'd1);

    // Async reset mid-track.
    pulse_after(4);
    async_reset();

    // Randomized trains, enable drops and resets.
    for (int s = 0; s < 300; s++) begin
      int r, g, w, l;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        en = 1'b1;
      end else if (r < 6) begin
        async_reset();
      end else begin
        g = (r < 70) ? PERIOD : int'($urandom_range(2, PERIOD + 4));
        w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15)) : 1;
        l = (g - w < 1) ? 1 : g - w;
        pulse_in = 1'b1;
        repeat (w) tick();
        pulse_in = 1'b0;
        repeat (l) tick();
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_period_checker.md
# pulse_period_checker

Receive-side monitor for a periodic single-cycle pulse stream, such as the output of the every-N-cycles pulse generator. While enabled, it detects rising edges on `pulse_in` and measures the cycle gap between consecutive edges. It flags early and late (missing) pulses, declares lock after a run of correct intervals, and keeps saturating good and error counters. The block sits at the consuming end of the pulse link and provides self-check and status for the generator.

## Interface
- `PERIOD`, default 10: expected gap between rising edges, in clk cycles; must be >= 2.
- `LOCK_COUNT`, default 3: consecutive good intervals required to assert `locked`; must be >= 1.
- `CNT_W`, default 16: width of the interval and event counters; must hold PERIOD+1.

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  asynchronous reset, active-high; clears all state.
- `en`  input  1  checking enable (the level companion of the generator's `start`).
- `pulse_in`  input  1  monitored pulse (the generator's `op_sig`).
- `locked`  output  1  high after LOCK_COUNT consecutive good intervals.
- `err_early`  output  1  one-cycle strobe: an edge arrived with gap < PERIOD.
- `err_late`  output  1  one-cycle strobe: no edge by gap == PERIOD.
- `interval`  output  CNT_W  gap measured at the last edge seen in TRACK.
- `good_count`  output  CNT_W  count of good intervals; saturating.
- `err_count`  output  CNT_W  count of early plus late errors; saturating.

## Operation
- Edge detect:
  - `pulse_d` is a register of `pulse_in` and updates in every state.
  - `edge = pulse_in & ~pulse_d`.
  - A level held high therefore yields one edge.
- Gap counter `gap`:
  - On `edge`, `gap <= 1`; otherwise `gap <= gap + 1`.
  - Saturates at all-ones.
  - At an edge exactly PERIOD cycles after the previous edge, the sampled `gap` equals PERIOD.
- FSM states: IDLE, ACQUIRE, TRACK.
  - IDLE: `en=1` moves to ACQUIRE. An edge on the same cycle is ignored.
  - ACQUIRE: the first `edge` moves to TRACK with `gap <= 1`. No counter changes.
  - TRACK, `edge` with `gap == PERIOD`: good interval.
    - `good_count++` and `run++`.
    - `locked <= 1` when `run+1 >= LOCK_COUNT`.
  - TRACK, `edge` with `gap < PERIOD`:
    - `err_early` strobe and `err_count++`.
    - `run <= 0`, `locked <= 0`.
    - Stay in TRACK; the gap restarts from this edge.
  - TRACK, no `edge` and `gap == PERIOD`:
    - `err_late` strobe and `err_count++`.
    - `run <= 0`, `locked <= 0`.
    - Go to ACQUIRE.
  - TRACK, any `edge`: `interval <= gap`.
  - Any state, `en=0`:
    - Go to IDLE; `locked <= 0`, `run <= 0`, `gap <= 0`.
    - `interval`, `good_count` and `err_count` are held.
- Counters: only reset clears them. Each holds at all-ones once saturated.

## Timing
- Reset values:
  - `locked=0`, `err_early=0`, `err_late=0`.
  - `interval=0`, `good_count=0`, `err_count=0`.
  - State IDLE, `gap=0`, `run=0`, `pulse_d=0`.
- All outputs are registered. The response to an edge sampled at clock edge k is visible after edge k (one-cycle latency from sampling).
- `err_early` and `err_late` are high for exactly one cycle per event and are never high together.
- `err_late` is raised at clock edge k+PERIOD when the last edge was sampled at edge k.
- Simultaneous events:
  - `en=0` plus `edge`: `en` wins. No count, no strobe.
  - An `edge` at exactly `gap == PERIOD` is good, never late.
- Reset mid-operation clears everything immediately, independent of clk. The first edge after release with `en=1` is the IDLE→ACQUIRE cycle.
- `locked` falls on the same cycle the error strobe rises.

## Test plan
All scenarios use PERIOD=10 and LOCK_COUNT=3.
- Reset: assert `rst` for 2 cycles between clocks -> all outputs 0 asynchronously and state IDLE.
- Nominal: `en=1`, then 1-cycle pulses every 10 cycles.
  - 1st pulse acquires; 2nd–4th pulses give `good_count` 1, 2, 3.
  - `locked=1` after the 4th pulse; `interval=10`, `err_count=0`.
- Early pulse: while locked, a pulse arrives 7 cycles after the previous one.
  - `err_early` is high for 1 cycle, `locked=0`, `err_count=1`, `interval=7`.
  - The next pulse 10 cycles later is counted good.
- Missing pulse: while locked, pulses stop.
  - `err_late` strobes 10 cycles after the last edge, `locked=0`, state ACQUIRE.
  - The next pulse re-acquires without a count change.
- Stuck-high: `pulse_in` held high for 25 cycles after an edge.
  - Exactly one `err_late` follows, with no `err_early`.
- Enable and reset mid-stream:
  - Drop `en` while locked -> `locked=0`; counts are held; pulses are ignored while `en=0`.
  - Re-enable -> needs 4 pulses to relock.
  - Async `rst` mid-TRACK -> all counters 0.
